// File: rtl/idu_queue.sv
// Instruction decode queue: decodes RV instructions on enqueue and holds the decoded fields
// in a small FIFO. The outputs present the oldest entry and read as zero when the queue is empty.
module idu_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic                     d0en,
  output logic                     s1en,
  output logic                     s2en,
  output logic [XLEN-1:0]          d0imm,
  output logic [4:0]               s1,
  output logic [XLEN-1:0]          s2imm,
  output logic [9:0]               fun,
  output logic [5:0]               itype,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CntMax = (PtrW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            d0en;
    logic            s1en;
    logic            s2en;
    logic [XLEN-1:0] d0imm;
    logic [4:0]      s1;
    logic [XLEN-1:0] s2imm;
    logic [9:0]      fun;
    logic [5:0]      itype;
    logic            illegal;
  } entry_t;

  logic [6:0]      w_opcode;
  logic            w_r, w_i, w_s, w_b, w_u, w_j, w_env, w_ill;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  entry_t          w_dec;
  entry_t          w_head;
  logic            w_push, w_pop;

  entry_t          r_mem [DEPTH];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [PtrW:0]   r_count;

  assign w_opcode = in_inst[6:0];
  assign w_env    = (w_opcode == 7'b1110011);

  always_comb begin
    w_r = 1'b0; w_i = 1'b0; w_s = 1'b0; w_b = 1'b0; w_u = 1'b0; w_j = 1'b0; w_ill = 1'b0;
    case (w_opcode)
      7'b0110011:                                     w_r = 1'b1;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: w_i = 1'b1;
      7'b0100011:                                     w_s = 1'b1;
      7'b1100011:                                     w_b = 1'b1;
      7'b0110111, 7'b0010111:                         w_u = 1'b1;
      7'b1101111:                                     w_j = 1'b1;
      default:                                        w_ill = 1'b1;
    endcase
  end

  // Signed casts sign-extend each immediate from inst[31] up to XLEN.
  assign w_imm_i = XLEN'($signed(in_inst[31:20]));
  assign w_imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign w_imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21],
                                  1'b0}));

  always_comb begin
    w_dec         = '0;
    w_dec.pc      = in_pc;
    w_dec.itype   = {w_r, w_i, w_s, w_b, w_u, w_j};
    w_dec.illegal = w_ill;
    w_dec.d0en    = w_r | w_u | w_j | (w_i & ~w_env);
    w_dec.s1en    = w_r | w_s | w_b | (w_i & ~w_env);
    w_dec.s2en    = w_r | w_s | w_b;

    if (w_dec.d0en)    w_dec.d0imm = XLEN'(in_inst[11:7]);
    else if (w_s)      w_dec.d0imm = w_imm_s;
    else if (w_b)      w_dec.d0imm = w_imm_b;

    if (w_dec.s1en)    w_dec.s1 = in_inst[19:15];

    if (w_dec.s2en)    w_dec.s2imm = XLEN'(in_inst[24:20]);
    else if (w_i)      w_dec.s2imm = w_imm_i;
    else if (w_u)      w_dec.s2imm = w_imm_u;
    else if (w_j)      w_dec.s2imm = w_imm_j;

    if (!(w_u | w_j | w_ill)) w_dec.fun[9:7] = in_inst[14:12];
    if (w_r)                  w_dec.fun[6:0] = in_inst[31:25];
  end

  // Flush wins over both same-cycle handshakes.
  assign in_ready  = (r_count < CntMax) & ~rst;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + (PtrW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (PtrW+1)'(1);
    end
  end

  always_comb begin
    w_head = '0;
    if (out_valid) w_head = r_mem[r_rptr];
  end

  assign count   = r_count;
  assign out_pc  = w_head.pc;
  assign d0en    = w_head.d0en;
  assign s1en    = w_head.s1en;
  assign s2en    = w_head.s2en;
  assign d0imm   = w_head.d0imm;
  assign s1      = w_head.s1;
  assign s2imm   = w_head.s2imm;
  assign fun     = w_head.fun;
  assign itype   = w_head.itype;
  assign illegal = w_head.illegal;

endmodule

// File: tb/tb_idu_queue.sv
// Directed bench for idu_queue: decode vectors, backpressure, flush, reset and a 64-bit instance.
module tb_idu_queue;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, d0imm, s2imm;
  logic        d0en, s1en, s2en, illegal;
  logic [4:0]  s1;
  logic [9:0]  fun;
  logic [5:0]  itype;
  logic [1:0]  count;

  logic        in_valid_64, in_ready_64, out_valid_64, out_ready_64;
  logic [31:0] in_inst_64;
  logic [63:0] in_pc_64, out_pc_64, d0imm_64, s2imm_64;
  logic        d0en_64, s1en_64, s2en_64, illegal_64;
  logic [4:0]  s1_64;
  logic [9:0]  fun_64;
  logic [5:0]  itype_64;
  logic [2:0]  count_64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  idu_queue #(.XLEN(32), .DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .d0en(d0en), .s1en(s1en), .s2en(s2en), .d0imm(d0imm), .s1(s1),
    .s2imm(s2imm), .fun(fun), .itype(itype), .illegal(illegal), .count(count)
  );

  idu_queue #(.XLEN(64), .DEPTH(4)) u_dut_64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid_64), .in_ready(in_ready_64),
    .in_inst(in_inst_64), .in_pc(in_pc_64), .out_valid(out_valid_64),
    .out_ready(out_ready_64), .out_pc(out_pc_64), .d0en(d0en_64), .s1en(s1en_64),
    .s2en(s2en_64), .d0imm(d0imm_64), .s1(s1_64), .s2imm(s2imm_64), .fun(fun_64),
    .itype(itype_64), .illegal(illegal_64), .count(count_64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_dec(input string tag, input logic [5:0] t, input logic d0e,
                           input logic s1e, input logic s2e, input logic [31:0] di,
                           input logic [4:0] s1v, input logic [31:0] s2i,
                           input logic [9:0] f, input logic ill);
    check({tag, ".itype"},   itype,   t);
    check({tag, ".d0en"},    d0en,    d0e);
    check({tag, ".s1en"},    s1en,    s1e);
    check({tag, ".s2en"},    s2en,    s2e);
    check({tag, ".d0imm"},   d0imm,   di);
    check({tag, ".s1"},      s1,      s1v);
    check({tag, ".s2imm"},   s2imm,   s2i);
    check({tag, ".fun"},     fun,     f);
    check({tag, ".illegal"}, illegal, ill);
  endtask

  task automatic push1(input logic [31:0] inst, input logic [31:0] pc);
    in_inst  = inst;
    in_pc    = pc;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h10;
    in_valid_64 = 1'b0; out_ready_64 = 1'b0; in_inst_64 = '0; in_pc_64 = '0;
    #1;
    check("rst.count",     count,     0);
    check("rst.in_ready",  in_ready,  0);
    check("rst.out_valid", out_valid, 0);
    check("rst.d0imm",     d0imm,     0);
    check("rst.itype",     itype,     0);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1;
    check("idle.in_ready", in_ready, 1);

    push1(32'hFFF00093, 32'h100);  // addi x1,x0,-1
    check("addi.count", count, 1);
    check("addi.out_valid", out_valid, 1);
    check("addi.out_pc", out_pc, 32'h100);
    check_dec("addi", 6'b010000, 1, 1, 0, 32'd1, 5'd0, 32'hFFFFFFFF, 10'h0, 0);
    pop1();
    check("empty.count", count, 0);
    check("empty.out_valid", out_valid, 0);
    check("empty.out_pc", out_pc, 0);
    check_dec("empty", 6'b0, 0, 0, 0, 32'd0, 5'd0, 32'd0, 10'h0, 0);

    push1(32'h0020A423, 32'h104);  // sw x2,8(x1)
    check_dec("sw", 6'b001000, 0, 1, 1, 32'd8, 5'd1, 32'd2, 10'h100, 0);
    pop1();
    push1(32'hFE000EE3, 32'h108);  // beq x0,x0,-4
    check_dec("beq", 6'b000100, 0, 1, 1, 32'hFFFFFFFC, 5'd0, 32'd0, 10'h0, 0);
    pop1();
    push1(32'h402081B3, 32'h10C);  // sub x3,x1,x2
    check_dec("sub", 6'b100000, 1, 1, 1, 32'd3, 5'd1, 32'd2, 10'h020, 0);
    pop1();
    push1(32'h008000EF, 32'h110);  // jal x1,8
    check_dec("jal", 6'b000001, 1, 0, 0, 32'd1, 5'd0, 32'd8, 10'h0, 0);
    pop1();
    push1(32'h300312F3, 32'h114);  // csrrw x5,0x300,x6
    check_dec("csrrw", 6'b010000, 0, 0, 0, 32'd0, 5'd0, 32'h300, 10'h080, 0);
    pop1();
    push1(32'h0000007F, 32'h118);
    check_dec("illegal", 6'b000000, 0, 0, 0, 32'd0, 5'd0, 32'd0, 10'h0, 1);
    check("illegal.out_pc", out_pc, 32'h118);
    pop1();

    // Backpressure: A and B fill the queue, C waits until a slot opens.
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h200;
    @(posedge clk); #1;
    check("bp.count1", count, 1);
    in_inst = 32'h0020A423; in_pc = 32'h204;
    @(posedge clk); #1;
    check("bp.count2", count, 2);
    check("bp.full_ready", in_ready, 0);
    in_inst = 32'h402081B3; in_pc = 32'h208;
    @(posedge clk); #1;
    check("bp.held_count", count, 2);
    check("bp.head_a", out_pc, 32'h200);
    out_ready = 1'b1;
    #1;
    check("bp.full_ready_oready", in_ready, 0);
    @(posedge clk); #1;
    check("bp.pop_a_count", count, 1);
    check("bp.head_b", out_pc, 32'h204);
    check("bp.head_b_fun", fun, 10'h100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp.simul_count", count, 1);
    check("bp.head_c", out_pc, 32'h208);
    check("bp.head_c_fun", fun, 10'h020);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp.drained", count, 0);
    check("bp.drained_valid", out_valid, 0);

    push1(32'hFFF00093, 32'h300);
    check("flush.pre_count", count, 1);
    in_inst = 32'h0020A423; in_pc = 32'h304; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush.count", count, 0);
    check("flush.out_valid", out_valid, 0);
    @(posedge clk); #1;
    check("flush.dropped_count", count, 0);
    check("flush.dropped_valid", out_valid, 0);

    push1(32'hFFF00093, 32'h400);
    push1(32'h0020A423, 32'h404);
    check("mrst.pre_count", count, 2);
    rst = 1'b1;
    #1;
    check("mrst.count", count, 0);
    check("mrst.out_valid", out_valid, 0);
    check("mrst.in_ready", in_ready, 0);
    check("mrst.d0imm", d0imm, 0);
    rst = 1'b0;
    push1(32'hFE000EE3, 32'h408);
    check("mrst.new_count", count, 1);
    check("mrst.new_head", out_pc, 32'h408);
    check("mrst.new_itype", itype, 6'b000100);
    pop1();

    in_inst_64 = 32'h800002B7; in_pc_64 = 64'hFFFF_0000_0000_1000; in_valid_64 = 1'b1;
    @(posedge clk); #1;
    in_inst_64 = 32'hFFF00093; in_pc_64 = 64'h2000;
    @(posedge clk); #1;
    in_valid_64 = 1'b0;
    check("lui64.count", count_64, 2);
    check("lui64.out_pc", out_pc_64, 64'hFFFF_0000_0000_1000);
    check("lui64.itype", itype_64, 6'b000010);
    check("lui64.s2imm", s2imm_64, 64'hFFFF_FFFF_8000_0000);
    check("lui64.d0imm", d0imm_64, 64'd5);
    check("lui64.d0en", d0en_64, 1);
    check("lui64.s1en", s1en_64, 0);
    out_ready_64 = 1'b1;
    @(posedge clk); #1;
    out_ready_64 = 1'b0;
    check("addi64.out_pc", out_pc_64, 64'h2000);
    check("addi64.s2imm", s2imm_64, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi64.count", count_64, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
